mole_round_scheduler: RTL and testbench

Game sequencer for the whack-a-mole design. It owns the game state machine, the 60-second round timer, per-mole lifetime and cooldown, score and miss counters, and difficulty ramp. It sits between the keypad hit-detection path, the LFSR position source and the dot-matrix/7-segment display blocks. The scheduler decides when a mole is shown, where it is shown, and for how long.

---
 rtl/mole_round_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_mole_round_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_scheduler.sv
// ============================================================================
//  Module      : mole_round_scheduler
//  Description : Game sequencer for the whack-a-mole design. Owns the round
//                state machine, the round timer (seconds remaining), the
//                per-mole lifetime and the empty-board cooldown, the score
//                and miss counters, and the difficulty ramp that shortens
//                the mole lifetime on every hit.
//
//  Ports
//    clk          : the only clock, rising-edge
//    rst          : asynchronous, active-high reset
//    i_tick       : single-cycle timebase strobe (TICKS_PER_SEC per second)
//    i_start      : start request, honoured only in IDLE or OVER
//    i_hit        : current mole struck (debounced, single-cycle)
//    i_rand_row   : pseudo-random row candidate for the next mole
//    i_rand_col   : pseudo-random column candidate for the next mole
//    o_is_started : a round is in progress
//    o_mole_valid : a mole is displayed and can be hit
//    o_mole_row   : row of the current mole
//    o_mole_col   : column of the current mole
//    o_time_left  : seconds remaining in the round
//    o_score      : hits this round (saturating at MAX_SCORE)
//    o_misses     : moles that timed out this round (saturating at 255)
//    o_game_over  : one-cycle pulse when a round ends
//
//  Revision    : 1.0  initial release
// ============================================================================

`default_nettype none

module mole_round_scheduler #(
    parameter int TICKS_PER_SEC     = 1000,
    parameter int GAME_TIME         = 60,
    parameter int MOLE_TIMEOUT_INIT = 1500,
    parameter int MOLE_TIMEOUT_MIN  = 400,
    parameter int TIMEOUT_STEP      = 100,
    parameter int COOLDOWN_TICKS    = 200,
    parameter int MAX_SCORE         = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_start,
    input  logic       i_hit,
    input  logic [1:0] i_rand_row,
    input  logic [1:0] i_rand_col,
    output logic       o_is_started,
    output logic       o_mole_valid,
    output logic [1:0] o_mole_row,
    output logic [1:0] o_mole_col,
    output logic [5:0] o_time_left,
    output logic [9:0] o_score,
    output logic [7:0] o_misses,
    output logic       o_game_over
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int SEC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [SEC_W-1:0] c_sec_last      = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [5:0]       c_game_time     = 6'(GAME_TIME);
    localparam logic [15:0]      c_timeout_init  = 16'(MOLE_TIMEOUT_INIT);
    localparam logic [15:0]      c_timeout_min   = 16'(MOLE_TIMEOUT_MIN);
    localparam logic [15:0]      c_timeout_step  = 16'(TIMEOUT_STEP);
    localparam logic [15:0]      c_cool_last     = 16'(COOLDOWN_TICKS - 1);
    localparam logic [9:0]       c_max_score     = 10'(MAX_SCORE);
    localparam logic [7:0]       c_max_misses    = 8'd255;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_ACTIVE   = 3'd2,
        S_COOLDOWN = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    state_t           r_state;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [SEC_W-1:0] r_sec_cnt;       // ticks within the current second
    logic [15:0]      r_mole_timer;    // ticks the current mole has been up
    logic [15:0]      r_cool_cnt;      // ticks spent in the empty-board gap
    logic [15:0]      r_cur_timeout;   // current mole lifetime in ticks
    logic             r_is_started;
    logic             r_mole_valid;
    logic [1:0]       r_mole_row;
    logic [1:0]       r_mole_col;
    logic [5:0]       r_time_left;
    logic [9:0]       r_score;
    logic [7:0]       r_misses;
    logic             r_game_over;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_playing;
    logic             w_second_done;
    logic             w_mole_expired;
    logic             w_cool_done;
    logic [1:0]       w_spawn_col;
    logic [15:0]      w_stepped_timeout;
    logic [15:0]      w_next_timeout;
    logic [9:0]       w_score_inc;
    logic [7:0]       w_misses_inc;

    always_comb begin
        w_playing = (r_state == S_SPAWN) || (r_state == S_ACTIVE) ||
                    (r_state == S_COOLDOWN);

        w_second_done  = i_tick && (r_sec_cnt == c_sec_last);
        w_mole_expired = i_tick && (r_mole_timer == (r_cur_timeout - 16'd1));
        w_cool_done    = i_tick && (r_cool_cnt == c_cool_last);

        // Never respawn on the square just vacated: nudge the column so the
        // player always sees the mole move.
        if ({i_rand_row, i_rand_col} == {r_mole_row, r_mole_col}) begin
            w_spawn_col = i_rand_col + 2'd1;
        end else begin
            w_spawn_col = i_rand_col;
        end

        // Difficulty ramp: subtract the step without wrapping below zero,
        // then clamp to the lifetime floor.
        w_stepped_timeout = 16'd0;
        if (r_cur_timeout > c_timeout_step) begin
            w_stepped_timeout = r_cur_timeout - c_timeout_step;
        end
        if (w_stepped_timeout < c_timeout_min) begin
            w_next_timeout = c_timeout_min;
        end else begin
            w_next_timeout = w_stepped_timeout;
        end

        w_score_inc  = (r_score >= c_max_score)   ? r_score  : r_score + 10'd1;
        w_misses_inc = (r_misses == c_max_misses) ? r_misses : r_misses + 8'd1;
    end

    // ------------------------------------------------------------------------
    // Game state machine, round timer and counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sec_cnt     <= '0;
            r_mole_timer  <= 16'd0;
            r_cool_cnt    <= 16'd0;
            r_cur_timeout <= c_timeout_init;
            r_is_started  <= 1'b0;
            r_mole_valid  <= 1'b0;
            r_mole_row    <= 2'd0;
            r_mole_col    <= 2'd0;
            r_time_left   <= c_game_time;
            r_score       <= 10'd0;
            r_misses      <= 8'd0;
            r_game_over   <= 1'b0;
        end else begin
            r_game_over <= 1'b0;

            case (r_state)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        r_time_left   <= c_game_time;
                        r_score       <= 10'd0;
                        r_misses      <= 8'd0;
                        r_cur_timeout <= c_timeout_init;
                        r_sec_cnt     <= '0;
                        r_mole_timer  <= 16'd0;
                        r_cool_cnt    <= 16'd0;
                        r_is_started  <= 1'b1;
                        r_state       <= S_SPAWN;
                    end
                end

                S_SPAWN: begin
                    r_mole_row   <= i_rand_row;
                    r_mole_col   <= w_spawn_col;
                    r_mole_timer <= 16'd0;
                    r_mole_valid <= 1'b1;
                    r_state      <= S_ACTIVE;
                end

                S_ACTIVE: begin
                    // A hit takes priority over a coincident timeout.
                    if (i_hit) begin
                        r_score       <= w_score_inc;
                        r_cur_timeout <= w_next_timeout;
                        r_mole_valid  <= 1'b0;
                        r_cool_cnt    <= 16'd0;
                        r_state       <= S_COOLDOWN;
                    end else if (w_mole_expired) begin
                        r_misses     <= w_misses_inc;
                        r_mole_valid <= 1'b0;
                        r_cool_cnt   <= 16'd0;
                        r_state      <= S_COOLDOWN;
                    end else if (i_tick) begin
                        r_mole_timer <= r_mole_timer + 16'd1;
                    end
                end

                S_COOLDOWN: begin
                    if (w_cool_done) begin
                        r_state <= S_SPAWN;
                    end else if (i_tick) begin
                        r_cool_cnt <= r_cool_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Round timer. Placed after the case so that round expiry
            // overrides whatever transition the playing state chose, while
            // score/miss updates made above in the same cycle still land.
            if (w_playing && i_tick) begin
                if (w_second_done) begin
                    r_sec_cnt   <= '0;
                    r_time_left <= r_time_left - 6'd1;
                    if (r_time_left == 6'd1) begin
                        r_state      <= S_OVER;
                        r_mole_valid <= 1'b0;
                        r_is_started <= 1'b0;
                        r_game_over  <= 1'b1;
                    end
                end else begin
                    r_sec_cnt <= r_sec_cnt + SEC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign o_is_started = r_is_started;
    assign o_mole_valid = r_mole_valid;
    assign o_mole_row   = r_mole_row;
    assign o_mole_col   = r_mole_col;
    assign o_time_left  = r_time_left;
    assign o_score      = r_score;
    assign o_misses     = r_misses;
    assign o_game_over  = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
// ============================================================================
//  Module      : tb_mole_round_scheduler
//  Description : Self-checking bench for mole_round_scheduler. Directed
//                stimulus; each expected output value is queued with the
//                cycle at which it must appear and compared when that cycle
//                is reached.
//  Revision    : 1.0  initial release
// ============================================================================

`default_nettype none

module tb_mole_round_scheduler;

    localparam int TPS  = 4;
    localparam int GT   = 3;
    localparam int TI   = 6;
    localparam int TMIN = 2;
    localparam int TS   = 2;
    localparam int CD   = 1;

    localparam int F_IS  = 0;
    localparam int F_MV  = 1;
    localparam int F_ROW = 2;
    localparam int F_COL = 3;
    localparam int F_TL  = 4;
    localparam int F_SC  = 5;
    localparam int F_MI  = 6;
    localparam int F_GO  = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start;
    logic       hit;
    logic [1:0] rand_row;
    logic [1:0] rand_col;
    logic       is_started;
    logic       mole_valid;
    logic [1:0] mole_row;
    logic [1:0] mole_col;
    logic [5:0] time_left;
    logic [9:0] score;
    logic [7:0] misses;
    logic       game_over;

    mole_round_scheduler #(
        .TICKS_PER_SEC     (TPS),
        .GAME_TIME         (GT),
        .MOLE_TIMEOUT_INIT (TI),
        .MOLE_TIMEOUT_MIN  (TMIN),
        .TIMEOUT_STEP      (TS),
        .COOLDOWN_TICKS    (CD),
        .MAX_SCORE         (999)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_tick       (tick),
        .i_start      (start),
        .i_hit        (hit),
        .i_rand_row   (rand_row),
        .i_rand_col   (rand_col),
        .o_is_started (is_started),
        .o_mole_valid (mole_valid),
        .o_mole_row   (mole_row),
        .o_mole_col   (mole_col),
        .o_time_left  (time_left),
        .o_score      (score),
        .o_misses     (misses),
        .o_game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   b      = 0;

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_IS:    observe = {31'd0, is_started};
            F_MV:    observe = {31'd0, mole_valid};
            F_ROW:   observe = {30'd0, mole_row};
            F_COL:   observe = {30'd0, mole_col};
            F_TL:    observe = {26'd0, time_left};
            F_SC:    observe = {22'd0, score};
            F_MI:    observe = {24'd0, misses};
            default: observe = {31'd0, game_over};
        endcase
    endfunction

    task automatic expect_at(input int off, input int fld, input int val, input string tag);
        exp_t e;
        e.cyc = cyc + off;
        e.fld = fld;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        logic [31:0] obs;
        int          i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                obs = observe(sb[i].fld);
                checks++;
                assert (obs === sb[i].val) else begin
                    errors++;
                    $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                           sb[i].tag, cyc, obs, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        rst      = 1'b1;
        tick     = 1'b1;
        start    = 1'b0;
        hit      = 1'b0;
        rand_row = 2'd0;
        rand_col = 2'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        expect_at(0, F_IS,  0, "rst_is_started");
        expect_at(0, F_MV,  0, "rst_mole_valid");
        expect_at(0, F_TL,  GT, "rst_time_left");
        expect_at(0, F_SC,  0, "rst_score");
        expect_at(0, F_MI,  0, "rst_misses");
        expect_at(0, F_GO,  0, "rst_game_over");
        expect_at(0, F_ROW, 0, "rst_row");
        expect_at(0, F_COL, 0, "rst_col");
        check_due();
        rst = 1'b0;
        step();

        // ---------------- Round 1: no hits, round length ----------------
        b = cyc;
        start = 1'b1; rand_row = 2'd2; rand_col = 2'd1;
        expect_at(1,  F_IS,  1, "r1_started");
        expect_at(1,  F_MV,  0, "r1_spawn_not_valid");
        expect_at(1,  F_TL,  3, "r1_time_left_load");
        expect_at(2,  F_MV,  1, "r1_mole_up");
        expect_at(2,  F_ROW, 2, "r1_row");
        expect_at(2,  F_COL, 1, "r1_col");
        expect_at(4,  F_TL,  3, "r1_tl_before_sec");
        expect_at(5,  F_TL,  2, "r1_tl_after_sec1");
        expect_at(7,  F_MV,  1, "r1_mole_last_cycle");
        expect_at(8,  F_MV,  0, "r1_mole_timeout");
        expect_at(8,  F_MI,  1, "r1_miss");
        expect_at(9,  F_MV,  0, "r1_spawn_gap");
        expect_at(9,  F_TL,  1, "r1_tl_after_sec2");
        expect_at(10, F_MV,  1, "r1_mole2_up");
        expect_at(10, F_ROW, 1, "r1_mole2_row");
        expect_at(10, F_COL, 2, "r1_mole2_col");
        expect_at(12, F_IS,  1, "r1_still_started");
        expect_at(12, F_GO,  0, "r1_no_early_over");
        expect_at(13, F_IS,  0, "r1_ended");
        expect_at(13, F_GO,  1, "r1_game_over");
        expect_at(13, F_TL,  0, "r1_tl_zero");
        expect_at(13, F_MV,  0, "r1_mole_cleared");
        expect_at(14, F_GO,  0, "r1_go_single_pulse");
        expect_at(15, F_ROW, 1, "r1_row_held");
        expect_at(15, F_COL, 2, "r1_col_held");
        expect_at(15, F_MI,  1, "r1_misses_held");
        expect_at(15, F_TL,  0, "r1_tl_held");
        step(); start = 1'b0;
        step_to(b + 9);
        rand_row = 2'd1; rand_col = 2'd2;
        step_to(b + 15);

        // ---------------- Round 2: restart, collision, ramp to 4 ----------
        b = cyc;
        start = 1'b1;                      // rand (1,2) equals current mole
        expect_at(1,  F_IS,  1, "r2_restart");
        expect_at(1,  F_SC,  0, "r2_score_clear");
        expect_at(1,  F_MI,  0, "r2_misses_clear");
        expect_at(1,  F_TL,  3, "r2_tl_reload");
        expect_at(2,  F_MV,  1, "r2_mole_up");
        expect_at(2,  F_ROW, 1, "r2_collide_row");
        expect_at(2,  F_COL, 3, "r2_collide_col");
        expect_at(3,  F_SC,  1, "r2_hit1_score");
        expect_at(3,  F_MV,  0, "r2_hit1_clear");
        expect_at(5,  F_MV,  1, "r2_mole2_up");
        expect_at(5,  F_ROW, 1, "r2_wrap_row");
        expect_at(5,  F_COL, 0, "r2_wrap_col");
        expect_at(8,  F_MV,  1, "r2_life4_last");
        expect_at(9,  F_MV,  0, "r2_life4_expired");
        expect_at(9,  F_MI,  1, "r2_miss");
        expect_at(10, F_SC,  1, "r2_cooldown_hit_ignored");
        expect_at(11, F_MV,  1, "r2_mole3_up");
        expect_at(11, F_ROW, 3, "r2_mole3_row");
        expect_at(11, F_COL, 3, "r2_mole3_col");
        expect_at(12, F_SC,  2, "r2_hit2_score");
        expect_at(13, F_GO,  1, "r2_game_over");
        expect_at(13, F_SC,  2, "r2_score_at_over");
        expect_at(13, F_MI,  1, "r2_misses_at_over");
        expect_at(15, F_SC,  2, "r2_score_held");
        expect_at(15, F_TL,  0, "r2_tl_held");
        step(); start = 1'b0;
        step(); hit = 1'b1;                // b+2: first ACTIVE cycle
        step(); hit = 1'b0;
        rand_row = 2'd1; rand_col = 2'd3;  // equals current (1,3)
        step_to(b + 9);
        hit = 1'b1;                        // COOLDOWN: ignored
        rand_row = 2'd3; rand_col = 2'd3;
        step(); hit = 1'b0;
        step(); hit = 1'b1;                // b+11: first ACTIVE cycle
        step(); hit = 1'b0;
        step_to(b + 15);

        // ---------------- Round 3: ramp 6->4->2, hit on timeout cycle -----
        b = cyc;
        start = 1'b1; rand_row = 2'd0; rand_col = 2'd0;
        expect_at(2,  F_ROW, 0, "r3_row");
        expect_at(2,  F_COL, 0, "r3_col");
        expect_at(3,  F_SC,  1, "r3_score1");
        expect_at(6,  F_SC,  2, "r3_score2");
        expect_at(8,  F_MV,  1, "r3_life2_first");
        expect_at(8,  F_ROW, 2, "r3_mole3_row");
        expect_at(9,  F_MV,  1, "r3_life2_last");
        expect_at(10, F_SC,  3, "r3_hit_on_timeout_score");
        expect_at(10, F_MI,  0, "r3_hit_on_timeout_misses");
        expect_at(10, F_MV,  0, "r3_hit_on_timeout_clear");
        expect_at(12, F_MV,  1, "r3_mole4_up");
        expect_at(13, F_GO,  1, "r3_game_over");
        expect_at(13, F_SC,  3, "r3_score_at_over");
        step(); start = 1'b0;
        step(); hit = 1'b1; rand_row = 2'd0; rand_col = 2'd1;   // b+2
        step(); hit = 1'b0;
        step_to(b + 5); hit = 1'b1; rand_row = 2'd2; rand_col = 2'd2;
        step(); hit = 1'b0;
        step_to(b + 9); hit = 1'b1;        // coincides with lifetime-2 timeout
        step(); hit = 1'b0;
        step_to(b + 15);

        // ---------------- Round 4: reset mid-round ------------------------
        b = cyc;
        start = 1'b1; rand_row = 2'd1; rand_col = 2'd1;
        expect_at(3, F_SC, 1, "r4_score_before_reset");
        step(); start = 1'b0;
        step(); hit = 1'b1;
        step(); hit = 1'b0;                // b+3
        rst = 1'b1;
        #2;
        expect_at(0, F_IS,  0, "r4_rst_is_started");
        expect_at(0, F_MV,  0, "r4_rst_mole_valid");
        expect_at(0, F_TL,  GT, "r4_rst_time_left");
        expect_at(0, F_SC,  0, "r4_rst_score");
        expect_at(0, F_GO,  0, "r4_rst_game_over");
        expect_at(0, F_ROW, 0, "r4_rst_row");
        expect_at(1, F_GO,  0, "r4_no_go_in_reset");
        check_due();
        step();
        rst = 1'b0;
        expect_at(1, F_GO, 0, "r4_no_go_after_reset");
        expect_at(1, F_IS, 0, "r4_idle_after_reset");
        step();
        start = 1'b1;
        expect_at(1, F_IS, 1, "r4_start_from_idle");
        step(); start = 1'b0;
        step();

        // Any expectation whose cycle was never reached is a failure.
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never checked (due cyc=%0d)", sb[i].tag, sb[i].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
